// File: rtl/rns2bin_crt.sv
// rtl/rns2bin_crt.sv - {8,7,5,3} RNS to signed binary reverse converter (CRT accumulation)
module rns2bin_crt (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] mod8,
  input  logic [2:0] mod7,
  input  logic [2:0] mod5,
  input  logic [1:0] mod3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] n_out,
  output logic       err
);

  // Dynamic range M = 8*7*5*3; results above M/2-1 wrap to negative.
  localparam logic [10:0] M_WIDE = 11'd840;
  localparam logic [9:0]  M_NARROW = 10'd840;
  localparam logic [9:0]  HALF_M = 10'd420;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CONV = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  r8, r7, r5;
  logic [1:0]  r3;
  logic [9:0]  acc;
  logic [1:0]  k;

  logic [9:0]  term;
  logic [10:0] sum;
  logic [9:0]  acc_next;
  logic        bad_tuple;
  logic [9:0]  signed_x;

  // Select the CRT term for the residue indexed by k; each term is r_i * weight_i mod 840.
  always_comb begin
    term = 10'd0;
    case (k)
      2'd0: term = 10'(r8) * 10'd105;
      2'd1: begin
        // r7 = 7 is non-canonical; contribute nothing so the term stays below 840.
        if (r7 == 3'd7) term = 10'd0;
        else            term = 10'(r7) * 10'd120;
      end
      2'd2: begin
        case (r5)
          3'd0:    term = 10'd0;
          3'd1:    term = 10'd336;
          3'd2:    term = 10'd672;
          3'd3:    term = 10'd168;
          3'd4:    term = 10'd504;
          default: term = 10'd0;
        endcase
      end
      2'd3: begin
        case (r3)
          2'd0:    term = 10'd0;
          2'd1:    term = 10'd280;
          2'd2:    term = 10'd560;
          default: term = 10'd0;
        endcase
      end
      default: term = 10'd0;
    endcase
  end

  // Modular accumulate: both operands are below 840, so a single conditional subtract reduces.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, term};
    acc_next = (sum >= M_WIDE) ? 10'(sum - M_WIDE) : sum[9:0];
  end

  // Flag non-canonical residues and map X in 0..839 onto the signed range -420..419.
  always_comb begin
    bad_tuple = (r7 == 3'd7) || (r5 >= 3'd5) || (r3 == 2'd3);
    signed_x  = (acc >= HALF_M) ? (acc - M_NARROW) : acc;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      n_out     <= 10'd0;
      err       <= 1'b0;
      acc       <= 10'd0;
      k         <= 2'd0;
      r8        <= 3'd0;
      r7        <= 3'd0;
      r5        <= 3'd0;
      r3        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r8       <= mod8;
            r7       <= mod7;
            r5       <= mod5;
            r3       <= mod3;
            acc      <= 10'd0;
            k        <= 2'd0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          k   <= k + 2'd1;
          if (k == 2'd3) state <= CONV;
        end
        CONV: begin
          // Invalid tuples still take the full latency but report zero.
          err       <= bad_tuple;
          n_out     <= bad_tuple ? 10'd0 : signed_x;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
